// File: rtl/io_pad_turnaround_arbiter.sv
// Two-requester arbiter for one bidirectional IO pad. Guard cycles with the pad
// undriven surround every drive burst, and pad input is registered while the pad listens.
module io_pad_turnaround_arbiter #(
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 16,
  parameter int CNT_W       = 8
) (
  input  logic UserCLK,
  input  logic RESETn,
  input  logic req_a,
  input  logic data_a,
  input  logic last_a,
  output logic gnt_a,
  output logic ready_a,
  input  logic req_b,
  input  logic data_b,
  input  logic last_b,
  output logic gnt_b,
  output logic ready_b,
  input  logic O_top,
  output logic I_top,
  output logic T_top,
  output logic rx_data,
  output logic rx_valid,
  output logic busy
);

  typedef enum logic [1:0] {IDLE, GUARD_IN, DRIVE, GUARD_OUT} state_e;
  typedef enum logic {OWN_A, OWN_B} owner_e;

  localparam logic [CNT_W-1:0] GUARD_LOAD = (TURN_CYCLES == 0) ? '0 : CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(MAX_BURST - 1);

  state_e           state_q;
  owner_e           owner_q;
  owner_e           last_owner_q;
  logic [CNT_W-1:0] guard_cnt_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic             i_top_q;
  logic             t_top_q;
  logic             rx_data_q;
  logic             rx_valid_q;

  logic   own_req;
  logic   own_data;
  logic   own_last;
  logic   any_req;
  owner_e owner_d;

  always_comb begin
    own_req  = (owner_q == OWN_B) ? req_b  : req_a;
    own_data = (owner_q == OWN_B) ? data_b : data_a;
    own_last = (owner_q == OWN_B) ? last_b : last_a;
    any_req  = req_a | req_b;
    // On a tie the requester that did not own the previous burst wins.
    if (req_a && req_b) begin
      owner_d = (last_owner_q == OWN_A) ? OWN_B : OWN_A;
    end else if (req_b) begin
      owner_d = OWN_B;
    end else begin
      owner_d = OWN_A;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= IDLE;
      owner_q      <= OWN_A;
      last_owner_q <= OWN_B;
      guard_cnt_q  <= '0;
      beat_cnt_q   <= '0;
      i_top_q      <= 1'b0;
      t_top_q      <= 1'b0;
      rx_data_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
    end else begin
      rx_data_q  <= O_top;
      rx_valid_q <= (state_q == IDLE) && !t_top_q;
      case (state_q)
        IDLE: begin
          t_top_q    <= 1'b0;
          i_top_q    <= 1'b0;
          beat_cnt_q <= '0;
          if (any_req) begin
            owner_q     <= owner_d;
            guard_cnt_q <= GUARD_LOAD;
            state_q     <= (TURN_CYCLES == 0) ? DRIVE : GUARD_IN;
          end
        end
        GUARD_IN: begin
          t_top_q <= 1'b0;
          if (!own_req) begin
            state_q      <= GUARD_OUT;
            guard_cnt_q  <= GUARD_LOAD;
            last_owner_q <= owner_q;
          end else if (guard_cnt_q == '0) begin
            state_q <= DRIVE;
          end else begin
            guard_cnt_q <= guard_cnt_q - 1'b1;
          end
        end
        DRIVE: begin
          if (own_req) begin
            i_top_q    <= own_data;
            t_top_q    <= 1'b1;
            beat_cnt_q <= beat_cnt_q + 1'b1;
            // Forced release keeps beat_cnt_q below its wrap point.
            if (own_last || (beat_cnt_q == BEAT_LAST)) begin
              state_q      <= GUARD_OUT;
              guard_cnt_q  <= GUARD_LOAD;
              last_owner_q <= owner_q;
            end
          end else begin
            t_top_q      <= 1'b0;
            state_q      <= GUARD_OUT;
            guard_cnt_q  <= GUARD_LOAD;
            last_owner_q <= owner_q;
          end
        end
        GUARD_OUT: begin
          t_top_q <= 1'b0;
          i_top_q <= 1'b0;
          if (guard_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            guard_cnt_q <= guard_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_a    = ((state_q == GUARD_IN) || (state_q == DRIVE)) && (owner_q == OWN_A);
  assign gnt_b    = ((state_q == GUARD_IN) || (state_q == DRIVE)) && (owner_q == OWN_B);
  assign ready_a  = (state_q == DRIVE) && (owner_q == OWN_A);
  assign ready_b  = (state_q == DRIVE) && (owner_q == OWN_B);
  assign busy     = (state_q != IDLE);
  assign I_top    = i_top_q;
  assign T_top    = t_top_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
